counter_seq_ctrl: RTL and testbench

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl_if.sv | 28 ++
 rtl/counter_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_if.sv
// Command / status bundle for counter_seq_ctrl.
// The master drives commands and control; the slave (the controller) drives status.
interface counter_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_limit;
  logic [REP_W-1:0] cmd_reps;
  logic             abort;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic [REP_W-1:0] reps_left;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_limit, cmd_reps, abort, pause,
    input  cmd_ready, count, wrap, reps_left, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_limit, cmd_reps, abort, pause,
    output cmd_ready, count, wrap, reps_left, busy, done
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Repeating up-counter sequencer: counts 0..limit for a commanded number of
// periods, pulsing wrap at each period end and done once on completion.
// Optional pause/hold support is compiled in with COUNTER_SEQ_CTRL_PAUSE_EN.
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_seq_ctrl_if.slave    bus
);

`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd3
  } state_e;

  // pause stays on the bundle but has no function in this build
  logic unused_pause_c;
  assign unused_pause_c = bus.pause;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [REP_W-1:0] reps_q,  reps_d;
  logic             wrap_q,  wrap_d;

  logic             at_limit_c;
  logic             last_rep_c;
  logic             ready_c;
  logic             busy_c;
  logic             done_c;

  assign at_limit_c = (count_q == limit_q);
  assign last_rep_c = (reps_q == REP_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort beats pause, pause beats terminal-count handling
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = (bus.cmd_reps == REP_W'(0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
        end else if (bus.pause) begin
          state_d = S_PAUSE;
`endif
        end else if (at_limit_c && last_rep_c) begin
          state_d = S_DONE;
        end
      end
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (!bus.pause) begin
          state_d = S_RUN;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore status decode
  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE:  ready_c = 1'b1;
      S_RUN:   busy_c  = 1'b1;
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
      S_PAUSE: busy_c  = 1'b1;
`endif
      S_DONE:  done_c  = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  // Datapath next values: command latch, count advance, period bookkeeping
  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    reps_d  = reps_q;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          limit_d = bus.cmd_limit;
          reps_d  = bus.cmd_reps;
          count_d = WIDTH'(0);
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          count_d = WIDTH'(0);
          reps_d  = REP_W'(0);
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
        end else if (bus.pause) begin
          count_d = count_q;
`endif
        end else if (at_limit_c) begin
          count_d = WIDTH'(0);
          wrap_d  = 1'b1;
          reps_d  = reps_q - REP_W'(1);
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (bus.abort) begin
          count_d = WIDTH'(0);
          reps_d  = REP_W'(0);
        end
      end
`endif
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= WIDTH'(0);
      limit_q <= WIDTH'(0);
      reps_q  <= REP_W'(0);
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      reps_q  <= reps_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.cmd_ready = ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.count     = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.reps_left = reps_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl (4-bit count, 4-bit reps).
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_counter_seq_ctrl;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  counter_seq_ctrl_if #(.WIDTH(4), .REP_W(4)) bus ();

  counter_seq_ctrl #(.WIDTH(4), .REP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command in the current (IDLE) cycle and advance to the first cycle after acceptance
  task automatic issue(input logic [3:0] lim, input logic [3:0] reps);
    check("accept_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_limit = lim;
    bus.cmd_reps  = reps;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    int exp_wrap;
    tests_run    = 0;
    tests_failed = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_limit = '0;
    bus.cmd_reps  = '0;
    bus.abort     = 1'b0;
    bus.pause     = 1'b0;

    // Reset state
    step();
    step();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_wrap",  32'(bus.wrap),  32'd0);
    rst = 1'b0;
    step();
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_reps",  32'(bus.reps_left), 32'd0);

    // limit=3 reps=2, with a stray command during RUN that must be ignored
    issue(4'd3, 4'd2);
    for (int i = 1; i <= 8; i++) begin
      check("basic_count", 32'(bus.count), 32'((i - 1) % 4));
      check("basic_wrap",  32'(bus.wrap),  32'(i == 5));
      check("basic_busy",  32'(bus.busy),  32'd1);
      check("basic_done",  32'(bus.done),  32'd0);
      check("basic_reps",  32'(bus.reps_left), (i < 5) ? 32'd2 : 32'd1);
      if (i == 2) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_limit = 4'd7;
        bus.cmd_reps  = 4'd5;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      step();
    end
    check("basic_done_pulse", 32'(bus.done),      32'd1);
    check("basic_last_wrap",  32'(bus.wrap),      32'd1);
    check("basic_done_busy",  32'(bus.busy),      32'd0);
    check("basic_done_ready", 32'(bus.cmd_ready), 32'd0);
    check("basic_done_count", 32'(bus.count),     32'd0);
    check("basic_done_reps",  32'(bus.reps_left), 32'd0);
    step();
    check("basic_idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("basic_idle_done",  32'(bus.done),      32'd0);
    check("basic_idle_wrap",  32'(bus.wrap),      32'd0);

    // limit=0 reps=3: wrap on three consecutive cycles, done with the third
    issue(4'd0, 4'd3);
    check("l0_first_wrap", 32'(bus.wrap),      32'd0);
    check("l0_first_reps", 32'(bus.reps_left), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("l0_count", 32'(bus.count), 32'd0);
      check("l0_wrap",  32'(bus.wrap),  32'd1);
      check("l0_done",  32'(bus.done),  32'(i == 3));
      check("l0_reps",  32'(bus.reps_left), 32'(3 - i));
    end
    step();
    check("l0_after_wrap",  32'(bus.wrap),      32'd0);
    check("l0_after_ready", 32'(bus.cmd_ready), 32'd1);

    // reps=0: straight to DONE, nothing runs
    issue(4'd5, 4'd0);
    check("r0_done",  32'(bus.done),  32'd1);
    check("r0_count", 32'(bus.count), 32'd0);
    check("r0_wrap",  32'(bus.wrap),  32'd0);
    check("r0_busy",  32'(bus.busy),  32'd0);
    step();
    check("r0_ready", 32'(bus.cmd_ready), 32'd1);

    // Full range limit=15 reps=1: natural wrap from all-ones
    issue(4'd15, 4'd1);
    for (int i = 1; i <= 16; i++) begin
      check("full_count", 32'(bus.count), 32'(i - 1));
      check("full_wrap",  32'(bus.wrap),  32'd0);
      check("full_done",  32'(bus.done),  32'd0);
      step();
    end
    check("full_end_done",  32'(bus.done),  32'd1);
    check("full_end_wrap",  32'(bus.wrap),  32'd1);
    check("full_end_count", 32'(bus.count), 32'd0);
    step();

    // Abort together with pause at count=2
    issue(4'd9, 4'd3);
    step();
    step();
    check("abort_pre_count", 32'(bus.count), 32'd2);
    bus.abort = 1'b1;
    bus.pause = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.pause = 1'b0;
    check("abort_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_count", 32'(bus.count),     32'd0);
    check("abort_reps",  32'(bus.reps_left), 32'd0);
    check("abort_wrap",  32'(bus.wrap),      32'd0);
    check("abort_busy",  32'(bus.busy),      32'd0);
    check("abort_done",  32'(bus.done),      32'd0);
    step();
    check("abort_no_done", 32'(bus.done), 32'd0);

    // Abort in IDLE does nothing
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_idle_busy",  32'(bus.busy),      32'd0);

    // Pause for 4 cycles at count=5, limit=9
    issue(4'd9, 4'd2);
    for (int i = 0; i < 5; i++) step();
    check("pause_pre_count", 32'(bus.count), 32'd5);
    bus.pause = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) bus.pause = 1'b0;
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
      exp_cnt  = (k <= 5) ? 5 : 6;
      exp_wrap = 0;
`else
      exp_cnt  = (5 + k) % 10;
      exp_wrap = (k == 5) ? 1 : 0;
`endif
      check("pause_count", 32'(bus.count), 32'(exp_cnt));
      check("pause_wrap",  32'(bus.wrap),  32'(exp_wrap));
      check("pause_busy",  32'(bus.busy),  32'd1);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("pause_exit_ready", 32'(bus.cmd_ready), 32'd1);

    // Reset in mid-RUN at count=3
    issue(4'd9, 4'd2);
    step();
    step();
    step();
    check("mrst_pre_count", 32'(bus.count), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_count", 32'(bus.count),     32'd0);
    check("mrst_busy",  32'(bus.busy),      32'd0);
    check("mrst_done",  32'(bus.done),      32'd0);
    check("mrst_reps",  32'(bus.reps_left), 32'd0);
    step();
    check("mrst_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("mrst_no_done", 32'(bus.done), 32'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
